id_ex_fwd_stage: RTL and testbench

- ID/EX pipeline register plus forwarding and load-use hazard control for the 5-stage MIPS pipeline.
- Latches decoded operands and register specifiers from ID.
- Drives the 2-bit select of each EX-stage operand forwarding mux.
- Stalls IF/ID and inserts a bubble on load-use hazards.

---
 rtl/id_ex_fwd_stage_pkg.sv | 24 ++
 rtl/id_ex_fwd_stage_fwd_sel_logic.sv | 48 ++++
 rtl/id_ex_fwd_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_fwd_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_fwd_stage_pkg
//  Description : Shared constants for the ID/EX stage of the 5-stage MIPS
//                pipeline: operand forwarding mux select encodings, the
//                hard-wired zero register index and default datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_ex_fwd_stage_pkg;

    // Default widths for the datapath and register specifiers
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_REG_AW = 5;

    // EX operand mux select encodings; 2'b11 is never produced
    localparam logic [1:0] FWD_REG   = 2'b00;  // registered operand
    localparam logic [1:0] FWD_WB    = 2'b01;  // MEM/WB write-back data
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // EX/MEM result

    // Register $0 reads as zero and must never be forwarded
    localparam int REG_ZERO = 0;

endpackage : id_ex_fwd_stage_pkg
`default_nettype wire

// File: rtl/id_ex_fwd_stage_fwd_sel_logic.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_logic
//  Description : Combinational forwarding select for one EX operand.
//                EX/MEM has priority over MEM/WB; $0 is never forwarded and
//                a bubble in EX always selects the registered operand.
//  Ports       : src             - EX-stage source register of this operand
//                valid           - EX holds a real instruction
//                exmem_reg_write - EX/MEM writes the register file
//                exmem_rd        - EX/MEM destination register
//                memwb_reg_write - MEM/WB writes the register file
//                memwb_rd        - MEM/WB destination register
//                sel             - 2-bit operand mux select
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel_logic
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic              valid,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        sel
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_reg_write && (exmem_rd != REG_AW'(REG_ZERO)) && (exmem_rd == src);
    assign hit_memwb = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == src);

    always_comb begin
        sel = FWD_REG;
        if (valid) begin
            if (hit_exmem) begin
                sel = FWD_EXMEM;  // most recent producer wins
            end else if (hit_memwb) begin
                sel = FWD_WB;
            end
        end
    end

endmodule : fwd_sel_logic
`default_nettype wire

// File: rtl/id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_fwd_stage
//  Description : ID/EX pipeline register with operand forwarding selects and
//                load-use hazard detection for a 5-stage MIPS pipeline.
//  Ports       : clk, rst_n        - clock and async active-low reset
//                id_*              - decoded instruction from ID
//                flush             - squash the ID instruction (bubble)
//                exmem_*, memwb_*  - downstream writers for forwarding
//                memwb_data        - write-back value this cycle
//                ex_*              - registered EX-stage instruction
//                fwd_a_sel/b_sel   - EX operand mux selects
//                stall             - hold PC and IF/ID for a load-use hazard
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_fwd_stage
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall
);

    logic wt_rs;
    logic wt_rt;

    // Load in EX whose result the ID instruction needs: the value is only
    // available after MEM, so one bubble is required. rs and rt are both
    // compared without decoding the format (conservative).
    assign stall = id_valid && ex_valid && ex_mem_read
                && (ex_rd != REG_AW'(REG_ZERO))
                && ((ex_rd == id_rs) || (ex_rd == id_rt));

    // Register file is written and read in the same cycle; the read value
    // from ID is stale, so take the write-back value directly.
    assign wt_rs = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == id_rs);
    assign wt_rt = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == id_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
        end else if (flush || stall) begin
            // Bubble; flush takes precedence but both produce the same value
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
        end else begin
            ex_valid     <= id_valid;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write && id_valid;
            ex_mem_read  <= id_mem_read && id_valid;
            ex_rs_data   <= wt_rs ? memwb_data : id_rs_data;
            ex_rt_data   <= wt_rt ? memwb_data : id_rt_data;
        end
    end

    fwd_sel_logic #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .src             (ex_rs),
        .valid           (ex_valid),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (fwd_a_sel)
    );

    fwd_sel_logic #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .src             (ex_rt),
        .valid           (ex_valid),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (fwd_b_sel)
    );

endmodule : id_ex_fwd_stage
`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_fwd_stage
//  Description : Self-checking bench for id_ex_fwd_stage: directed scenarios
//                plus a randomized run against a behavioural pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_fwd_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, id_mem_read;
    logic [31:0] id_rs_data, id_rt_data;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [31:0] ex_rs_data, ex_rt_data;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    id_ex_fwd_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .ex_valid        (ex_valid),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rs_data      (ex_rs_data),
        .ex_rt_data      (ex_rt_data),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall           (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and step just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0;
        id_rs_data = 0; id_rt_data = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic rw, input logic mr,
                           input logic [31:0] a, input logic [31:0] b);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; id_rs_data = a; id_rt_data = b;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #7;
        rst_n = 1;
        tick();
    endtask

    // ---------------------------------------------------------------- reset
    task automatic test_reset();
        do_reset();
        checks++;
        if (ex_valid !== 1'b0 || ex_rs_data !== 32'h0 || stall !== 1'b0 || fwd_a_sel !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: valid=%b rs_data=%h stall=%b fa=%b want 0/0/0/00",
                     ex_valid, ex_rs_data, stall, fwd_a_sel);
        end
        // Load in EX with rs=5, forwarded from EX/MEM, and a dependent ID op
        present(5'd5, 5'd6, 5'd8, 1, 1, 32'hA5A5A5A5, 32'h5A5A5A5A);
        tick();
        present(5'd8, 5'd1, 5'd9, 1, 0, 32'h1, 32'h2);
        exmem_reg_write = 1; exmem_rd = 5'd5;
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_a_sel !== 2'b10 || ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: stall=%b fa=%b valid=%b want 1/10/1", stall, fwd_a_sel, ex_valid);
        end
        #1 rst_n = 0;  // mid-cycle, no clock edge
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_rs_data !== 32'h0 || fwd_a_sel !== 2'b00 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: valid=%b rs_data=%h fa=%b stall=%b want 0/0/00/0",
                     ex_valid, ex_rs_data, fwd_a_sel, stall);
        end
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    // -------------------------------------------------------- fwd priority
    task automatic test_priority();
        idle_inputs();
        present(5'd5, 5'd6, 5'd3, 1, 0, 32'h10, 32'h20);
        tick();
        idle_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd5;
        memwb_reg_write = 1; memwb_rd = 5'd5;
        #1;
        checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL prio_exmem: fa=%b fb=%b want 10/00", fwd_a_sel, fwd_b_sel);
        end
        exmem_reg_write = 0;
        #1;
        checks++;
        if (fwd_a_sel !== 2'b01) begin
            failures++;
            $display("FAIL prio_memwb: fa=%b want 01", fwd_a_sel);
        end
        exmem_reg_write = 1; exmem_rd = 5'd6;
        #1;
        checks++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b10) begin
            failures++;
            $display("FAIL prio_split: fa=%b fb=%b want 01/10", fwd_a_sel, fwd_b_sel);
        end
        // Bubble in EX: selects must both read 00
        tick();
        #1;
        checks++;
        if (ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL prio_bubble: valid=%b fa=%b fb=%b want 0/00/00", ex_valid, fwd_a_sel, fwd_b_sel);
        end
    endtask

    // ---------------------------------------------------------- $0 guard
    task automatic test_zero_guard();
        idle_inputs();
        present(5'd0, 5'd0, 5'd4, 1, 0, 32'h3, 32'h4);
        tick();
        idle_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd0;
        memwb_reg_write = 1; memwb_rd = 5'd0;
        #1;
        checks++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            failures++;
            $display("FAIL zero_guard: fa=%b fb=%b want 00/00", fwd_a_sel, fwd_b_sel);
        end
        // A load writing $0 must not stall a reader of $0
        present(5'd1, 5'd2, 5'd0, 1, 1, 32'h0, 32'h0);
        exmem_reg_write = 0; memwb_reg_write = 0;
        tick();
        present(5'd0, 5'd0, 5'd3, 1, 0, 32'h0, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL zero_stall: stall=%b want 0", stall);
        end
        tick();
    endtask

    // ---------------------------------------------------------- load-use
    task automatic test_load_use();
        idle_inputs();
        present(5'd1, 5'd2, 5'd8, 1, 1, 32'h100, 32'h0);  // lw $8
        tick();
        present(5'd8, 5'd3, 5'd9, 1, 0, 32'h0, 32'h33);   // add $9,$8,$3
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall: stall=%b want 1", stall);
        end
        tick();
        exmem_reg_write = 1; exmem_rd = 5'd8;             // lw now in EX/MEM
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble: valid=%b rw=%b mr=%b stall=%b want 0/0/0/0",
                     ex_valid, ex_reg_write, ex_mem_read, stall);
        end
        tick();
        exmem_reg_write = 0; exmem_rd = 5'd0;             // bubble in EX/MEM
        memwb_reg_write = 1; memwb_rd = 5'd8;             // lw in MEM/WB
        memwb_data = 32'hCAFE0008;
        id_valid = 0;
        #1;
        checks++;
        if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rd !== 5'd9 || stall !== 1'b0 || fwd_a_sel !== 2'b01) begin
            failures++;
            $display("FAIL lu_capture: valid=%b rs=%0d rd=%0d stall=%b fa=%b want 1/8/9/0/01",
                     ex_valid, ex_rs, ex_rd, stall, fwd_a_sel);
        end
        tick();
    endtask

    // ----------------------------------------------------- write-through
    task automatic test_write_through();
        idle_inputs();
        present(5'd7, 5'd3, 5'd2, 1, 0, 32'h11111111, 32'h22222222);
        memwb_reg_write = 1; memwb_rd = 5'd7; memwb_data = 32'hDEADBEEF;
        tick();
        checks++;
        if (ex_rs_data !== 32'hDEADBEEF || ex_rt_data !== 32'h22222222) begin
            failures++;
            $display("FAIL wt_rs: rs_data=%h rt_data=%h want deadbeef/22222222", ex_rs_data, ex_rt_data);
        end
        present(5'd4, 5'd0, 5'd2, 1, 0, 32'h44444444, 32'h55555555);
        memwb_rd = 5'd0;                                   // $0 write ignored
        tick();
        checks++;
        if (ex_rs_data !== 32'h44444444 || ex_rt_data !== 32'h55555555) begin
            failures++;
            $display("FAIL wt_zero: rs_data=%h rt_data=%h want 44444444/55555555", ex_rs_data, ex_rt_data);
        end
        memwb_rd = 5'd9;
        present(5'd1, 5'd9, 5'd2, 1, 0, 32'h66666666, 32'h77777777);
        tick();
        checks++;
        if (ex_rs_data !== 32'h66666666 || ex_rt_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wt_rt: rs_data=%h rt_data=%h want 66666666/deadbeef", ex_rs_data, ex_rt_data);
        end
    endtask

    // ------------------------------------------------ flush during stall
    task automatic test_flush_stall();
        idle_inputs();
        present(5'd1, 5'd2, 5'd4, 1, 1, 32'h0, 32'h0);    // lw $4
        tick();
        present(5'd4, 5'd5, 5'd6, 1, 0, 32'h0, 32'h0);
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL fs_stall: stall=%b want 1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL fs_bubble: valid=%b rw=%b want 0/0", ex_valid, ex_reg_write);
        end
        flush = 0;
        present(5'd4, 5'd5, 5'd10, 1, 0, 32'hABCD, 32'h1234);
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_reg_write !== 1'b1 || ex_rs_data !== 32'hABCD) begin
            failures++;
            $display("FAIL fs_next: valid=%b rd=%0d rw=%b rs_data=%h want 1/10/1/abcd",
                     ex_valid, ex_rd, ex_reg_write, ex_rs_data);
        end
    endtask

    // ---------------------------------------------------------- random
    // Reference model: what instruction EX holds, and the rules for choosing
    // forwarding sources and stalling, evaluated per cycle.
    typedef struct {
        bit          valid;
        bit [4:0]    rs, rt, rd;
        bit          rw, mr;
        bit [31:0]   a, b;
    } ex_slot_t;

    ex_slot_t m;

    function automatic bit [1:0] model_sel(input bit [4:0] src);
        if (!m.valid) return 2'd0;
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == src) return 2'd2;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        return id_valid && m.valid && m.mr && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt);
    endfunction

    function automatic bit [31:0] read_val(input bit [4:0] r, input bit [31:0] rf);
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_data;
        return rf;
    endfunction

    task automatic test_random();
        bit st;
        do_reset();
        m = '{default: 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 7));
            id_rt           = 5'($urandom_range(0, 7));
            id_rd           = 5'($urandom_range(0, 7));
            id_reg_write    = 1'($urandom);
            id_mem_read     = ($urandom_range(0, 2) == 0);
            id_rs_data      = $urandom;
            id_rt_data      = $urandom;
            flush           = ($urandom_range(0, 9) == 0);
            exmem_reg_write = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 7));
            memwb_reg_write = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 7));
            memwb_data      = $urandom;
            #2;
            st = model_stall();
            checks++;
            if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read} !==
                {m.valid, m.rs, m.rt, m.rd, m.rw, m.mr}) begin
                failures++;
                $display("FAIL rnd_ctrl c%0d: got v%b rs%0d rt%0d rd%0d rw%b mr%b want v%b rs%0d rt%0d rd%0d rw%b mr%b",
                         cyc, ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read,
                         m.valid, m.rs, m.rt, m.rd, m.rw, m.mr);
            end
            checks++;
            if (ex_rs_data !== m.a || ex_rt_data !== m.b) begin
                failures++;
                $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", cyc, ex_rs_data, ex_rt_data, m.a, m.b);
            end
            checks++;
            if (fwd_a_sel !== model_sel(m.rs) || fwd_b_sel !== model_sel(m.rt) || stall !== st) begin
                failures++;
                $display("FAIL rnd_comb c%0d: fa=%b fb=%b stall=%b want %b/%b/%b",
                         cyc, fwd_a_sel, fwd_b_sel, stall, model_sel(m.rs), model_sel(m.rt), st);
            end
            // Next EX contents: a bubble on flush or hazard, else the ID op
            if (flush || st) begin
                m = '{default: 0};
            end else begin
                m.valid = id_valid;
                m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
                m.rw = id_reg_write && id_valid;
                m.mr = id_mem_read && id_valid;
                m.a  = read_val(id_rs, id_rs_data);
                m.b  = read_val(id_rt, id_rt_data);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_priority();
        test_zero_guard();
        test_load_use();
        test_write_through();
        test_flush_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_fwd_stage
`default_nettype wire
